// File: rtl/dmem_types.sv
// Shared types for the data-memory responder: FSM state encoding, timer width and data word.
package dmem_types;

  localparam int CNT_W = 4;

  typedef logic [31:0]      rv32i_word;
  typedef logic [CNT_W-1:0] dmem_cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Word-wide storage with a registered (synchronous) read port and per-byte write enables.
// Contents are deliberately never reset.
module dmem_sram_array
  import dmem_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output rv32i_word        rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_be,
  input  rv32i_word        wr_data
);

  rv32i_word mem [DEPTH_WORDS];
  rv32i_word rd_data_q;
  rv32i_word rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency, single-outstanding data-memory target for the MEM-stage data port.
// Build option DMEM_ERR_EN adds dmem_err (out-of-range or simultaneous read+write request).
//
// state | meaning
// IDLE  | waiting for dmem_read/dmem_write; captures the request when one is seen
// WAIT  | down-counting the remaining latency; leaves at terminal count 1
// RESP  | one-cycle dmem_resp; write committed on the closing edge; inputs ignored
module dmem_responder
  import dmem_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_address,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
`ifdef DMEM_ERR_EN
  output logic        dmem_err,
`endif
  output logic        dmem_resp
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [33:0] SPAN_BYTES = 34'(DEPTH_WORDS) << 2;
  localparam dmem_cnt_t   CNT_LOAD   = dmem_cnt_t'(LATENCY - 1);

  dmem_state_t      state_q, state_d;
  dmem_cnt_t        cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_range_q, in_range_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [3:0]       wmask_q, wmask_d;
  rv32i_word        wdata_q, wdata_d;

  rv32i_word        addr_off;
  logic             req_in_range;
  logic [IDX_W-1:0] req_idx;

  logic             sram_rd_en;
  logic [IDX_W-1:0] sram_rd_idx;
  rv32i_word        sram_rd_data;
  logic             sram_wr_en;

  // Unsigned offset: addresses below BASE_ADDR wrap high and land out of range.
  assign addr_off     = dmem_address - BASE_ADDR;
  assign req_in_range = {2'b00, addr_off} < SPAN_BYTES;
  assign req_idx      = addr_off[IDX_W+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (dmem_read || dmem_write) begin
          idx_d      = req_idx;
          in_range_d = req_in_range;
          rd_d       = dmem_read;
          wr_d       = dmem_write;
          wmask_d    = dmem_wmask;
          wdata_d    = dmem_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - dmem_cnt_t'(1);
        if (cnt_q == dmem_cnt_t'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wmask_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
    end
  end

  // Read is launched on the edge entering RESP; with LATENCY=1 that is also the capture
  // edge, so the index comes straight from the live address while still in IDLE.
  assign sram_rd_en  = (state_d == RESP);
  assign sram_rd_idx = (state_q == IDLE) ? req_idx : idx_q;
  assign sram_wr_en  = (state_q == RESP) && wr_q && in_range_q;

  dmem_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk    (clk),
    .rd_en  (sram_rd_en),
    .rd_idx (sram_rd_idx),
    .rd_data(sram_rd_data),
    .wr_en  (sram_wr_en),
    .wr_idx (idx_q),
    .wr_be  (wmask_q),
    .wr_data(wdata_q)
  );

  assign dmem_resp  = (state_q == RESP);
  assign dmem_rdata = (dmem_resp && rd_q && in_range_q) ? sram_rd_data : '0;

`ifdef DMEM_ERR_EN
  assign dmem_err = dmem_resp && (!in_range_q || (rd_q && wr_q));
`endif

endmodule
